// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255 PPI host-side bus sequencer.
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    // PPI register addresses
    localparam logic [1:0] PPI_A    = 2'b00;
    localparam logic [1:0] PPI_B    = 2'b01;
    localparam logic [1:0] PPI_C    = 2'b10;
    localparam logic [1:0] PPI_CTRL = 2'b11;

    // Control-word bit positions (mode-set flag and port direction bits)
    localparam int CW_MODE_BIT   = 7;
    localparam int CW_DIR_A_BIT  = 4;
    localparam int CW_DIR_CU_BIT = 3;
    localparam int CW_DIR_B_BIT  = 1;
    localparam int CW_DIR_CL_BIT = 0;

    // The control register cannot be read back, so such a read is refused.
    function automatic logic is_rejected(input logic we, input logic [1:0] addr);
        return !we && (addr == PPI_CTRL);
    endfunction

endpackage

// File: rtl/ppi_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advanced on accept.
module ppi_rr_arb2
    import ppi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    // Contested requests go to the favoured requester; a lone request wins outright.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant the pointer favours the requester that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ppi_bus_sequencer.sv
// Host-side sequencer for an 8255 PPI: shares the CPU bus between two
// requesters, times the CS/RD/WR strobes and writes the control word after reset.
// All bus outputs are registered from the next state so strobes are glitch-free.
module ppi_bus_sequencer
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [7:0]  CTRL_WORD  = 8'h80
) (
    input  logic       CLK,
    input  logic       RESETbar,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [1:0] ADDR0,
    input  logic [1:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       ERR,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic       CSbar,
    output logic       RDbar,
    output logic       WRbar,
    output logic [1:0] Addresslines,
    output logic [7:0] PortD_OUT,
    output logic       PortD_OE,
    input  logic [7:0] PortD_IN
);

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = (HOLD_CYC == 0) ? 4'd0 : 4'(HOLD_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       init_q, init_d;       // current transaction is the init write
    logic       sel_q, sel_d;         // granted requester
    logic       rej_q, rej_d;         // rejected control-register read
    logic       init_done_q, init_done_d;
    logic [7:0] rdata_q, rdata_d;

    logic       cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic [1:0] ad_q, ad_d;
    logic [7:0] pdo_q, pdo_d;
    logic       ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;

    logic       grant;
    logic [1:0] gnt;
    logic       bus;

    ppi_rr_arb2 u_arb (
        .clk_i   (CLK),
        .rst_ni  (RESETbar),
        .req_i   ({REQ1, REQ0}),
        .accept_i(grant),
        .gnt_o   (gnt)
    );

    // Next-state logic: transaction capture, phase timing and read sampling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        init_d      = init_q;
        sel_d       = sel_q;
        rej_d       = rej_q;
        init_done_d = init_done_q;
        rdata_d     = rdata_q;
        grant       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!init_done_q) begin
                    init_d  = 1'b1;
                    rej_d   = 1'b0;
                    we_d    = 1'b1;
                    addr_d  = PPI_CTRL;
                    data_d  = CTRL_WORD;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end else if (REQ0 || REQ1) begin
                    grant   = 1'b1;
                    init_d  = 1'b0;
                    sel_d   = gnt[1];
                    we_d    = gnt[1] ? WE1    : WE0;
                    addr_d  = gnt[1] ? ADDR1  : ADDR0;
                    data_d  = gnt[1] ? WDATA1 : WDATA0;
                    rej_d   = is_rejected(we_d, addr_d);
                    cnt_d   = '0;
                    state_d = rej_d ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    if (!we_q) begin
                        rdata_d = PortD_IN;
                    end
                    cnt_d   = '0;
                    state_d = (HOLD_CYC == 0) ? ST_DONE : ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (init_q) begin
                    init_done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so the registered outputs track the state register.
    always_comb begin
        bus    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_d   = !bus;
        wr_d   = !((state_d == ST_STROBE) && we_d);
        rd_d   = !((state_d == ST_STROBE) && !we_d);
        ad_d   = bus ? addr_d : PPI_A;
        oe_d   = bus && we_d;
        pdo_d  = oe_d ? data_d : 8'h00;
        ack0_d = (state_d == ST_DONE) && !init_d && !sel_d;
        ack1_d = (state_d == ST_DONE) && !init_d && sel_d;
        err_d  = (state_d == ST_DONE) && !init_d && rej_d;
        busy_d = (state_d != ST_IDLE);
    end

    // State, transaction and output registers; reset aborts any bus cycle at once.
    always_ff @(posedge CLK or negedge RESETbar) begin
        if (!RESETbar) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            init_q      <= 1'b0;
            sel_q       <= 1'b0;
            rej_q       <= 1'b0;
            init_done_q <= !INIT_EN;
            rdata_q     <= '0;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            oe_q        <= 1'b0;
            ad_q        <= '0;
            pdo_q       <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            init_q      <= init_d;
            sel_q       <= sel_d;
            rej_q       <= rej_d;
            init_done_q <= init_done_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            ad_q        <= ad_d;
            pdo_q       <= pdo_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign CSbar        = cs_q;
    assign RDbar        = rd_q;
    assign WRbar        = wr_q;
    assign Addresslines = ad_q;
    assign PortD_OUT    = pdo_q;
    assign PortD_OE     = oe_q;
    assign ACK0         = ack0_q;
    assign ACK1         = ack1_q;
    assign ERR          = err_q;
    assign RDATA        = rdata_q;
    assign BUSY         = busy_q;
    assign INIT_DONE    = init_done_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Self-checking bench for ppi_bus_sequencer: directed vector table, hand-written
// init/arbitration/reset sequences, and randomized two-requester traffic against
// a transaction-level model.
module tb_ppi_bus_sequencer;

    logic       CLK = 1'b0;
    logic       RESETbar = 1'b0;
    logic       REQ0 = 0, REQ1 = 0, WE0 = 0, WE1 = 0;
    logic [1:0] ADDR0 = 0, ADDR1 = 0;
    logic [7:0] WDATA0 = 0, WDATA1 = 0;
    logic       ACK0, ACK1, ERR, BUSY, INIT_DONE, CSbar, RDbar, WRbar, PortD_OE;
    logic [7:0] RDATA, PortD_OUT, PortD_IN;
    logic [1:0] Addresslines;

    // Simple PPI register model on the far side of the bus
    logic [7:0] ppi_mem [4];
    logic       ovr_en = 1'b1;
    logic [7:0] pin_ovr = 8'h00;

    int checks = 0;
    int errors = 0;
    bit model_ptr = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] model_mem [4];

    ppi_bus_sequencer dut (
        .CLK(CLK), .RESETbar(RESETbar),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY),
        .INIT_DONE(INIT_DONE), .CSbar(CSbar), .RDbar(RDbar), .WRbar(WRbar),
        .Addresslines(Addresslines), .PortD_OUT(PortD_OUT), .PortD_OE(PortD_OE),
        .PortD_IN(PortD_IN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!CSbar && !WRbar) ppi_mem[Addresslines] <= PortD_OUT;
    end

    assign PortD_IN = ovr_en ? pin_ovr : ppi_mem[Addresslines];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit         r;
        bit         we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] pin;
        int         e_lat;
        bit         e_err;
        logic [7:0] e_rdata;
        int         e_cs;
        int         e_wr;
        int         e_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input bit r, input bit req, input bit we,
                           input logic [1:0] a, input logic [7:0] d);
        if (r) begin REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = d; end
        else   begin REQ0 = req; WE0 = we; ADDR0 = a; WDATA0 = d; end
    endtask

    // One isolated transaction from one requester, with strobe accounting.
    task automatic do_txn(input string tag, input vec_t v);
        int lat, cs, wr, rd, bad;
        bit got, err_seen;
        logic [7:0] rd_seen;
        lat = 0; cs = 0; wr = 0; rd = 0; bad = 0; got = 0; err_seen = 0; rd_seen = 0;
        pin_ovr = v.pin;
        set_req(v.r, 1'b1, v.we, v.addr, v.wdata);
        while (!got && lat < 20) begin
            step();
            lat++;
            if (!CSbar) begin cs++; if (Addresslines !== v.addr) bad++; end
            if (!WRbar) begin wr++; if (PortD_OUT !== v.wdata || !PortD_OE) bad++; end
            if (!RDbar) rd++;
            if (PortD_OE && !v.we) bad++;
            if (v.r ? ACK0 : ACK1) bad++;
            if (v.r ? ACK1 : ACK0) begin got = 1; err_seen = ERR; rd_seen = RDATA; end
            else if (ERR) bad++;
        end
        set_req(v.r, 1'b0, 1'b0, 2'b00, 8'h00);
        step();
        chk({tag, "_ack"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, "_err"}, 32'(err_seen), 32'(v.e_err));
        chk({tag, "_rdata"}, 32'(rd_seen), 32'(v.e_rdata));
        chk({tag, "_cs_cycles"}, 32'(cs), 32'(v.e_cs));
        chk({tag, "_wr_cycles"}, 32'(wr), 32'(v.e_wr));
        chk({tag, "_rd_cycles"}, 32'(rd), 32'(v.e_rd));
        chk({tag, "_bus_faults"}, 32'(bad), 32'd0);
        if (got) model_ptr = !v.r;
        if (got && !v.we && !v.e_err) model_rdata = v.pin;
    endtask

    initial begin
        vec_t tbl[8];
        int cs, wr, rd, bad, n, k, nack, alt_bad, gap_bad, high_run, wr_init, wr_user;
        bit exp_w, pre_ack, got, first_cs_low;
        bit pend[2];
        bit p_we[2];
        logic [1:0] p_addr[2];
        logic [7:0] p_d[2];
        int age[2];
        bit hist0 [0:799];
        bit hist1 [0:799];

        // ---------------- reset state and init write ----------------
        RESETbar = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 2'b00, 8'hAA);
        repeat (2) step();
        chk("rst_strobes", {29'd0, CSbar, RDbar, WRbar}, 32'd7);
        chk("rst_addr", 32'(Addresslines), 32'd0);
        chk("rst_portd", {23'd0, PortD_OE, PortD_OUT}, 32'd0);
        chk("rst_ack_err", {29'd0, ACK0, ACK1, ERR}, 32'd0);
        chk("rst_rdata", 32'(RDATA), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_init_done", 32'(INIT_DONE), 32'd0);
        RESETbar = 1'b1;

        cs = 0; wr = 0; bad = 0; n = 0; pre_ack = 0; first_cs_low = 0;
        while (n < 40) begin
            step();
            n++;
            if (n == 1) first_cs_low = !CSbar;
            if (INIT_DONE) break;
            if (ACK0 || ACK1 || ERR) pre_ack = 1;
            if (!CSbar) begin
                cs++;
                if (Addresslines !== 2'b11 || !PortD_OE || PortD_OUT !== 8'h80) bad++;
            end
            if (!WRbar) wr++;
            if (!RDbar) bad++;
        end
        chk("init_starts_next_cycle", 32'(first_cs_low), 32'd1);
        chk("init_done_set", 32'(INIT_DONE), 32'd1);
        chk("init_cs_cycles", 32'(cs), 32'd4);
        chk("init_wr_cycles", 32'(wr), 32'd2);
        chk("init_bus_values", 32'(bad), 32'd0);
        chk("init_no_ack", 32'(pre_ack), 32'd0);

        k = 0; wr = 0; bad = 0;
        while (!ACK0 && k < 20) begin
            step();
            k++;
            if (!WRbar) begin wr++; if (PortD_OUT !== 8'hAA || Addresslines !== 2'b00) bad++; end
        end
        chk("req0_after_init_latency", 32'(k), 32'd5);
        chk("req0_after_init_wr_cycles", 32'(wr), 32'd2);
        chk("req0_after_init_bus", 32'(bad), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        step();
        model_ptr = 1'b1;

        // ---------------- directed vector table ----------------
        tbl[0] = '{1'b1, 1'b1, 2'b00, 8'h0F, 8'h00, 5, 1'b0, 8'h00, 4, 2, 0};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h90, 5, 1'b0, 8'h90, 4, 0, 2};
        tbl[2] = '{1'b0, 1'b0, 2'b11, 8'h00, 8'h5A, 1, 1'b1, 8'h90, 0, 0, 0};
        tbl[3] = '{1'b1, 1'b1, 2'b10, 8'h55, 8'h00, 5, 1'b0, 8'h90, 4, 2, 0};
        tbl[4] = '{1'b0, 1'b0, 2'b10, 8'h00, 8'h3C, 5, 1'b0, 8'h3C, 4, 0, 2};
        tbl[5] = '{1'b1, 1'b0, 2'b11, 8'h00, 8'h77, 1, 1'b1, 8'h3C, 0, 0, 0};
        tbl[6] = '{1'b1, 1'b1, 2'b11, 8'h9B, 8'h00, 5, 1'b0, 8'h3C, 4, 2, 0};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 8'h00, 8'hC3, 5, 1'b0, 8'hC3, 4, 0, 2};
        for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

        // ---------------- both requesters held: alternation ----------------
        set_req(1'b0, 1'b1, 1'b1, 2'b00, 8'h11);
        set_req(1'b1, 1'b1, 1'b1, 2'b01, 8'h22);
        nack = 0; alt_bad = 0; gap_bad = 0; high_run = 100; exp_w = model_ptr;
        for (int i = 0; i < 60 && nack < 6; i++) begin
            step();
            if (CSbar) high_run++;
            else begin
                if (high_run > 0 && high_run < 2) gap_bad++;
                high_run = 0;
            end
            if (ACK0 || ACK1) begin
                if (ACK1 != exp_w || (ACK0 && ACK1)) alt_bad++;
                exp_w = !exp_w;
                nack++;
            end
        end
        chk("rr_ack_count", 32'(nack), 32'd6);
        chk("rr_alternation", 32'(alt_bad), 32'd0);
        chk("rr_cs_gap", 32'(gap_bad), 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        step();
        model_ptr = exp_w;

        // ---------------- reset during a write strobe ----------------
        set_req(1'b0, 1'b1, 1'b1, 2'b10, 8'h66);
        n = 0;
        while (WRbar && n < 20) begin step(); n++; end
        chk("abort_reached_strobe", 32'(WRbar), 32'd0);
        #2 RESETbar = 1'b0;
        #1;
        chk("abort_strobes_high", {29'd0, CSbar, RDbar, WRbar}, 32'd7);
        chk("abort_no_ack", {30'd0, ACK0, ERR}, 32'd0);
        chk("abort_init_done_clear", 32'(INIT_DONE), 32'd0);
        chk("abort_oe_off", 32'(PortD_OE), 32'd0);
        step();
        RESETbar = 1'b1;
        model_ptr = 1'b0;
        model_rdata = 8'h00;
        wr_init = 0; wr_user = 0; bad = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (!WRbar) begin
                if (!INIT_DONE && Addresslines == 2'b11 && PortD_OUT == 8'h80) wr_init++;
                else if (INIT_DONE && Addresslines == 2'b10 && PortD_OUT == 8'h66) wr_user++;
                else bad++;
            end
            if (ACK0) begin got = 1; if (!INIT_DONE) bad++; end
            if (ACK1) bad++;
        end
        chk("rerun_init_wr_cycles", 32'(wr_init), 32'd2);
        chk("rerun_user_wr_cycles", 32'(wr_user), 32'd2);
        chk("rerun_order", 32'(bad), 32'd0);
        chk("rerun_ack0", 32'(got), 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        step();
        model_ptr = 1'b1;

        // ---------------- preload PPI registers A/B/C ----------------
        for (int a = 0; a < 3; a++) begin
            vec_t v;
            v = '{a[0], 1'b1, 2'(a), 8'(8'h30 + a), 8'h00, 5, 1'b0, model_rdata, 4, 2, 0};
            do_txn($sformatf("preload%0d", a), v);
            model_mem[a] = 8'(8'h30 + a);
        end
        model_mem[3] = 8'h80;

        // ---------------- randomized two-requester traffic ----------------
        ovr_en = 1'b0;
        pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
        for (int t = 0; t < 800; t++) begin
            step();
            chk("rnd_bus_rules", 32'(!((!RDbar && !WRbar) ||
                                       ((!RDbar || !WRbar) && CSbar) ||
                                       (PortD_OE && !RDbar) ||
                                       (ACK0 && ACK1) ||
                                       (ERR && !ACK0 && !ACK1))), 32'd1);
            for (int r = 0; r < 2; r++) begin
                bit ack, rej;
                int L;
                ack = (r == 1) ? ACK1 : ACK0;
                if (ack) begin
                    if (!pend[r]) chk($sformatf("rnd_spurious_ack%0d", r), 32'd1, 32'd0);
                    else begin
                        rej = !p_we[r] && (p_addr[r] == 2'b11);
                        L = rej ? 1 : 5;
                        chk("rnd_req_at_grant",
                            32'((t >= L) ? ((r == 1) ? hist1[t-L] : hist0[t-L]) : 1'b0), 32'd1);
                        if (t >= L && ((r == 1) ? hist0[t-L] : hist1[t-L]))
                            chk("rnd_rr_order", 32'(r), 32'(model_ptr));
                        model_ptr = (r == 0);
                        chk("rnd_err", 32'(ERR), 32'(rej));
                        if (!p_we[r] && !rej) model_rdata = model_mem[p_addr[r]];
                        if (p_we[r]) model_mem[p_addr[r]] = p_d[r];
                        chk("rnd_rdata", 32'(RDATA), 32'(model_rdata));
                        pend[r] = 0;
                        age[r] = 0;
                        set_req(r[0], 1'b0, 1'b0, 2'b00, 8'h00);
                    end
                end else if (pend[r]) begin
                    age[r]++;
                    if (age[r] > 40) begin
                        chk($sformatf("rnd_timeout%0d", r), 32'd1, 32'd0);
                        pend[r] = 0;
                        age[r] = 0;
                        set_req(r[0], 1'b0, 1'b0, 2'b00, 8'h00);
                    end
                end
                if (!pend[r] && t < 740 && $urandom_range(0, 2) == 0) begin
                    pend[r]   = 1;
                    p_we[r]   = 1'($urandom_range(0, 1));
                    p_addr[r] = 2'($urandom_range(0, 3));
                    p_d[r]    = 8'($urandom);
                    set_req(r[0], 1'b1, p_we[r], p_addr[r], p_d[r]);
                end
            end
            hist0[t] = REQ0;
            hist1[t] = REQ1;
        end
        chk("rnd_drained", {30'd0, pend[1], pend[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppi_bus_sequencer.md
Name: ppi_bus_sequencer

Overview:
- Synchronous host-side controller for the 8255-style PPI chip. It shares the chip's CPU interface (CSbar, RDbar, WRbar, Addresslines, PortD) between two requesters using round-robin arbitration.
- It generates timed chip-select, read and write strobes.
- After reset it configures the PPI by writing a programmable control word to address 2'b11.
- Sits between on-chip masters and the PPI instance. The top level combines PortD_OUT, PortD_OE and PortD_IN into the chip's bidirectional PortD.

Parameters:
- SETUP_CYC, 1: cycles with CSbar low and address/data stable before the strobe (1..15).
- STROBE_CYC, 2: cycles with RDbar or WRbar low (1..15).
- HOLD_CYC, 1: cycles after the strobe with CSbar low and address/data held (0..15; 0 skips HOLD).
- INIT_EN, 1: 1 means perform the control-word write after reset.
- CTRL_WORD, 8'h80: control word written at init (I/O mode, all ports output).

Ports:
- CLK  in  1  single clock, rising edge.
- RESETbar  in  1  asynchronous, active-low reset.
- REQ0 / REQ1  in  1  transaction request, requester 0/1.
- WE0 / WE1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  2  PPI register address.
- WDATA0 / WDATA1  in  8  write data.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- ERR  out  1  pulses with ACK when the transaction was rejected.
- RDATA  out  8  read data; valid in the ACK cycle, held until the next ACK.
- BUSY  out  1  high when state != IDLE.
- INIT_DONE  out  1  high once the init write has completed.
- CSbar, RDbar, WRbar  out  1  PPI strobes, active-low.
- Addresslines  out  2  PPI address.
- PortD_OUT  out  8  data driven toward the PPI.
- PortD_OE  out  1  1 = drive PortD.
- PortD_IN  in  8  PortD as seen from the bus.

Behaviour:
- Reset (RESETbar=0, asynchronous):
  - CSbar=RDbar=WRbar=1, Addresslines=0, PortD_OUT=0, PortD_OE=0.
  - ACK0=ACK1=ERR=0, RDATA=0, BUSY=0.
  - INIT_DONE=0 if INIT_EN=1, else INIT_DONE=1.
  - State=IDLE, round-robin pointer=0.
  - Reset asserted mid-transaction aborts it immediately: strobes go high and no ACK is issued. Init reruns after release.
- State machine: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If INIT_DONE=0, load the internal transaction {write, addr 11, CTRL_WORD} and go to SETUP.
  - Else if any REQ is high, grant per the pointer and capture that requester's WE/ADDR/WDATA. Go to SETUP, or to DONE with ERR for a rejected read.
  - Requests are never granted while INIT_DONE=0.
- SETUP, SETUP_CYC cycles:
  - CSbar=0, Addresslines=captured address.
  - For writes: PortD_OE=1, PortD_OUT=captured data.
  - Then go to STROBE.
- STROBE, STROBE_CYC cycles:
  - WRbar=0 for writes, RDbar=0 for reads.
  - Reads sample PortD_IN into RDATA on the last STROBE cycle.
  - Then go to HOLD, or to DONE if HOLD_CYC=0.
- HOLD, HOLD_CYC cycles: CSbar=0 with strobes high; address and write data held. Then go to DONE.
- DONE, 1 cycle:
  - CSbar=1, PortD_OE=0, ACK of the granted requester=1.
  - For init: no ACK; INIT_DONE is set at the end of this cycle.
  - Always returns to IDLE, so at least 2 cycles of CSbar high separate bus transactions.
- Signal timing rules:
  - RDbar and WRbar are never low simultaneously.
  - A strobe is only low while CSbar is low.
  - PortD_OE is never 1 during a read.
- Arbitration:
  - With both REQs high, the requester the pointer favours wins.
  - After any grant the pointer moves to the other requester.
  - A single REQ is granted regardless of the pointer.
- Requester rule: hold REQ and its fields until ACK; drop REQ in the cycle after ACK unless issuing a new transaction. Fields are captured at grant; later changes are ignored.
- Write-only control register: a read with ADDR=2'b11 runs no bus cycle. Go IDLE→DONE, pulse ACK+ERR, leave RDATA unchanged; the pointer still advances.
- Cycle count per bus transaction from grant to ACK: SETUP_CYC+STROBE_CYC+HOLD_CYC+1. With defaults: 5.

Decomposition:
- Package ppi_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, DONE);
  - PPI address constants PPI_A=2'b00, PPI_B=2'b01, PPI_C=2'b10, PPI_CTRL=2'b11;
  - control-word bit constants: mode bit 7; direction bits 4, 3, 1, 0.
- One sub-module, ppi_rr_arb2: 2-way round-robin arbiter with a pointer register and one-hot grant, advanced on an accept pulse.
- Timing counter and FSM stay in the top.

Test Plan:
- Init, default parameters: release RESETbar → next cycle IDLE, then CSbar low 4 cycles, Addresslines=11, PortD_OE=1, PortD_OUT=8'h80, WRbar low exactly 2 cycles → INIT_DONE=1 afterwards; no ACK.
- REQ0 high during init → no grant until INIT_DONE=1. Then REQ0 write ADDR=00, WDATA=8'hAA → WRbar low 2 cycles with PortD_OUT=AA; ACK0 is 5 cycles after grant.
- REQ1 read ADDR=01, bench drives PortD_IN=8'h90 → RDbar low 2 cycles, PortD_OE=0 throughout; RDATA=8'h90 with ACK1.
- REQ0 and REQ1 held continuously → grants alternate 0,1,0,1; CSbar high ≥2 cycles between transactions.
- REQ0 read ADDR=11 → no strobe at all; ACK0 and ERR pulse 1 cycle after grant; RDATA unchanged.
- RESETbar low during STROBE of a write → WRbar and CSbar high immediately, no ACK; on release, init write is repeated before the pending REQ is granted.
